// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch inputs, writeback port, EX hazard info and registered decode outputs.
// The decode stage is the slave; the fetch/pipeline environment is the master.
interface decode_stage_if;
  logic        en;
  logic        flush;
  logic [31:0] instr_npc;
  logic [31:0] instruction;
  logic        branch_taken;
  logic        wb_wen;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic        ex_memread;
  logic [4:0]  ex_wsel;
  logic        stall;
  logic        halt;
  logic [31:0] de_instr;
  logic [31:0] de_npc;
  logic        de_branch_taken;
  logic [31:0] de_rdat1;
  logic [31:0] de_rdat2;
  logic [31:0] de_imm;
  logic [4:0]  de_wsel;
  logic        de_regwen;
  logic        de_memread;
  logic        de_memwrite;
  logic        de_halt;

  modport master (
    output en, flush, instr_npc, instruction, branch_taken,
           wb_wen, wb_wsel, wb_wdat, ex_memread, ex_wsel,
    input  stall, halt, de_instr, de_npc, de_branch_taken, de_rdat1, de_rdat2,
           de_imm, de_wsel, de_regwen, de_memread, de_memwrite, de_halt
  );

  modport slave (
    input  en, flush, instr_npc, instruction, branch_taken,
           wb_wen, wb_wsel, wb_wdat, ex_memread, ex_wsel,
    output stall, halt, de_instr, de_npc, de_branch_taken, de_rdat1, de_rdat2,
           de_imm, de_wsel, de_regwen, de_memread, de_memwrite, de_halt
  );
endinterface

// File: rtl/decode_stage.sv
// Pipeline decode stage: register file, immediate/control decode, load-use stall and halt FSM.
// Define WB_BYPASS_EN to forward same-cycle writeback data onto register reads.
module decode_stage #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input logic           CLK,
  input logic           nRST,
  decode_stage_if.slave bus
);

  typedef enum logic [1:0] {RUN, BUBBLE, HALTED} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        branchTaken;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [4:0]  wsel;
    logic        regwen;
    logic        memread;
    logic        memwrite;
    logic        halt;
  } deReg_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_e      state_q, state_d;
  deReg_t      de_q, de_d;
  deReg_t      decoded;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] rdat1, rdat2;
  logic        usesRt, hazard;

  assign opcode = bus.instruction[31:26];
  assign rs     = bus.instruction[25:21];
  assign rt     = bus.instruction[20:16];
  assign rd     = bus.instruction[15:11];
  assign funct  = bus.instruction[5:0];
  assign imm    = bus.instruction[15:0];

`ifdef WB_BYPASS_EN
  assign rdat1 = (bus.wb_wen && bus.wb_wsel != 5'd0 && bus.wb_wsel == rs) ? bus.wb_wdat : rf_q[rs];
  assign rdat2 = (bus.wb_wen && bus.wb_wsel != 5'd0 && bus.wb_wsel == rt) ? bus.wb_wdat : rf_q[rt];
`else
  assign rdat1 = rf_q[rs];
  assign rdat2 = rf_q[rt];
`endif

  // Only R-type, branches and stores consume rt as a source operand.
  assign usesRt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_SW);
  assign hazard = bus.ex_memread && (bus.ex_wsel != 5'd0) &&
                  ((bus.ex_wsel == rs) || (usesRt && bus.ex_wsel == rt));

  always_comb begin
    decoded             = '0;
    decoded.instr       = bus.instruction;
    decoded.npc         = bus.instr_npc;
    decoded.branchTaken = bus.branch_taken;
    decoded.rdat1       = rdat1;
    decoded.rdat2       = rdat2;
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      decoded.imm = {16'h0000, imm};
    else if (opcode == OP_LUI)
      decoded.imm = {imm, 16'h0000};
    else
      decoded.imm = {{16{imm[15]}}, imm};
    if (opcode == OP_RTYPE)
      decoded.wsel = rd;
    else if (opcode == OP_JAL)
      decoded.wsel = 5'd31;
    else
      decoded.wsel = rt;
    decoded.regwen = !((opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                       (opcode == OP_J) || (opcode == OP_RTYPE && funct == FN_JR) ||
                       (opcode == HALT_OP) || (bus.instruction == 32'd0));
    decoded.memread  = (opcode == OP_LW);
    decoded.memwrite = (opcode == OP_SW);
    decoded.halt     = (opcode == HALT_OP);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Flush beats a hazard; HALTED is only left through reset.
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        RUN: begin
          if (bus.flush)        state_d = RUN;
          else if (hazard)      state_d = BUBBLE;
          else if (decoded.halt) state_d = HALTED;
          else                  state_d = RUN;
        end
        BUBBLE: begin
          if (bus.flush)        state_d = RUN;
          else if (decoded.halt) state_d = HALTED;
          else                  state_d = RUN;
        end
        default: state_d = HALTED;
      endcase
    end
  end

  always_comb begin
    de_d = de_q;
    if (bus.en) begin
      case (state_q)
        RUN:     de_d = (bus.flush || hazard) ? '0 : decoded;
        BUBBLE:  de_d = bus.flush ? '0 : decoded;
        default: de_d = '0;
      endcase
    end
    bus.halt  = (state_q == HALTED);
    bus.stall = nRST && (!bus.en || (state_q == HALTED) ||
                         (state_q == RUN && hazard && !bus.flush));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) de_q <= '0;
    else       de_q <= de_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.wb_wen && bus.wb_wsel != 5'd0) begin
      rf_q[bus.wb_wsel] <= bus.wb_wdat;
    end
  end

  assign bus.de_instr        = de_q.instr;
  assign bus.de_npc          = de_q.npc;
  assign bus.de_branch_taken = de_q.branchTaken;
  assign bus.de_rdat1        = de_q.rdat1;
  assign bus.de_rdat2        = de_q.rdat2;
  assign bus.de_imm          = de_q.imm;
  assign bus.de_wsel         = de_q.wsel;
  assign bus.de_regwen       = de_q.regwen;
  assign bus.de_memread      = de_q.memread;
  assign bus.de_memwrite     = de_q.memwrite;
  assign bus.de_halt         = de_q.halt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
// Expected same-cycle register read follows WB_BYPASS_EN.
module tb_decode_stage;

  logic CLK = 1'b0;
  logic nRST;

  decode_stage_if bus();

  decode_stage #(.HALT_OP(6'b111111)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        bt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  wsel;
    logic        regwen;
    logic        mr;
    logic        mw;
    logic        dh;
    logic        stall;
    logic        halt;
  } exp_t;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADD35 = 32'h00A0_1820;
  localparam logic [31:0] ADD37 = 32'h00E0_1820;
  localparam logic [31:0] SW52  = 32'hAC45_0000;
  localparam logic [31:0] ORI4  = 32'h3404_8000;
  localparam logic [31:0] ADDI6 = 32'h2006_8000;
  localparam logic [31:0] LUI1  = 32'h3C01_1234;
  localparam logic [31:0] JAL   = 32'h0C00_0010;
  localparam logic [31:0] LW9   = 32'h8C49_0004;
  localparam logic [31:0] HALT  = 32'hFC00_0000;

`ifdef WB_BYPASS_EN
  localparam logic [31:0] R7_SAME_CYCLE = 32'h1234_5678;
`else
  localparam logic [31:0] R7_SAME_CYCLE = 32'h0000_0000;
`endif

  exp_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
    end
  endtask

  function automatic exp_t bub(input logic s, input logic h);
    exp_t e;
    e       = '0;
    e.stall = s;
    e.halt  = h;
    return e;
  endfunction

  function automatic exp_t dec(input logic [31:0] instr, npc, input logic bt,
                               input logic [31:0] rd1, rd2, imm, input logic [4:0] wsel,
                               input logic regwen, mr, mw, dh, s, h);
    exp_t e;
    e.instr = instr; e.npc = npc; e.bt = bt; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    e.wsel = wsel; e.regwen = regwen; e.mr = mr; e.mw = mw; e.dh = dh; e.stall = s; e.halt = h;
    return e;
  endfunction

  task automatic applyStimulus(input logic rstN, en, flush, input logic [31:0] instr, npc,
                               input logic bt, wbWen, input logic [4:0] wbWsel,
                               input logic [31:0] wbWdat, input logic exMr,
                               input logic [4:0] exWsel, input exp_t e);
    @(posedge CLK);
    #1;
    nRST             = rstN;
    bus.en           = en;
    bus.flush        = flush;
    bus.instruction  = instr;
    bus.instr_npc    = npc;
    bus.branch_taken = bt;
    bus.wb_wen       = wbWen;
    bus.wb_wsel      = wbWsel;
    bus.wb_wdat      = wbWdat;
    bus.ex_memread   = exMr;
    bus.ex_wsel      = exWsel;
    sbQ.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("de_instr",        bus.de_instr,                 e.instr);
      checkOutput("de_npc",          bus.de_npc,                   e.npc);
      checkOutput("de_branch_taken", {31'd0, bus.de_branch_taken}, {31'd0, e.bt});
      checkOutput("de_rdat1",        bus.de_rdat1,                 e.rd1);
      checkOutput("de_rdat2",        bus.de_rdat2,                 e.rd2);
      checkOutput("de_imm",          bus.de_imm,                   e.imm);
      checkOutput("de_wsel",         {27'd0, bus.de_wsel},         {27'd0, e.wsel});
      checkOutput("de_regwen",       {31'd0, bus.de_regwen},       {31'd0, e.regwen});
      checkOutput("de_memread",      {31'd0, bus.de_memread},      {31'd0, e.mr});
      checkOutput("de_memwrite",     {31'd0, bus.de_memwrite},     {31'd0, e.mw});
      checkOutput("de_halt",         {31'd0, bus.de_halt},         {31'd0, e.dh});
      checkOutput("stall",           {31'd0, bus.stall},           {31'd0, e.stall});
      checkOutput("halt",            {31'd0, bus.halt},            {31'd0, e.halt});
    end
  end

  initial begin
    nRST = 1'b0;
    bus.en = 1'b1; bus.flush = 1'b0; bus.instruction = NOP; bus.instr_npc = '0;
    bus.branch_taken = 1'b0; bus.wb_wen = 1'b0; bus.wb_wsel = '0; bus.wb_wdat = '0;
    bus.ex_memread = 1'b0; bus.ex_wsel = '0;

    // Reset, then load r5 and r2 through the writeback port.
    applyStimulus(0, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0, bub(0, 0));
    applyStimulus(1, 1, 0, NOP, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, bub(0, 0));
    applyStimulus(1, 1, 0, NOP, 0, 0, 1, 2, 32'h0000_1000, 0, 0, bub(0, 0));
    // ADD r3,r5,r0, then an en=0 cycle holding its outputs.
    applyStimulus(1, 1, 0, ADD35, 32'h104, 1, 0, 0, 0, 0, 0, bub(0, 0));
    applyStimulus(1, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0,
                  dec(ADD35, 32'h104, 1, 32'hDEADBEEF, 0, 32'h1820, 3, 1, 0, 0, 0, 1, 0));
    applyStimulus(1, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0,
                  dec(ADD35, 32'h104, 1, 32'hDEADBEEF, 0, 32'h1820, 3, 1, 0, 0, 0, 0, 0));
    // Load-use hazard on SW rt: one stall, one bubble, then the store.
    applyStimulus(1, 1, 0, SW52, 32'h108, 0, 0, 0, 0, 1, 5, bub(1, 0));
    applyStimulus(1, 1, 0, SW52, 32'h108, 0, 0, 0, 0, 0, 0, bub(0, 0));
    applyStimulus(1, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0,
                  dec(SW52, 32'h108, 0, 32'h1000, 32'hDEADBEEF, 0, 5, 0, 0, 1, 0, 0, 0));
    // Immediate and destination variants.
    applyStimulus(1, 1, 0, ORI4, 32'h10C, 0, 0, 0, 0, 0, 0, bub(0, 0));
    applyStimulus(1, 1, 0, ADDI6, 32'h110, 0, 0, 0, 0, 0, 0,
                  dec(ORI4, 32'h10C, 0, 0, 0, 32'h0000_8000, 4, 1, 0, 0, 0, 0, 0));
    applyStimulus(1, 1, 0, LUI1, 32'h114, 0, 0, 0, 0, 0, 0,
                  dec(ADDI6, 32'h110, 0, 0, 0, 32'hFFFF_8000, 6, 1, 0, 0, 0, 0, 0));
    applyStimulus(1, 1, 0, JAL, 32'h118, 1, 0, 0, 0, 0, 0,
                  dec(LUI1, 32'h114, 0, 0, 0, 32'h1234_0000, 1, 1, 0, 0, 0, 0, 0));
    applyStimulus(1, 1, 0, LW9, 32'h11C, 0, 0, 0, 0, 0, 0,
                  dec(JAL, 32'h118, 1, 0, 0, 32'h0000_0010, 31, 1, 0, 0, 0, 0, 0));
    // Flush coincident with a hazard wins: no stall, bubble, ADD discarded.
    applyStimulus(1, 1, 1, ADD35, 32'h120, 1, 0, 0, 0, 1, 5,
                  dec(LW9, 32'h11C, 0, 32'h1000, 0, 32'h0000_0004, 9, 1, 1, 0, 0, 0, 0));
    applyStimulus(1, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0, bub(0, 0));
    // Same-cycle write and read of r7.
    applyStimulus(1, 1, 0, ADD37, 32'h124, 0, 1, 7, 32'h1234_5678, 0, 0, bub(0, 0));
    applyStimulus(1, 1, 0, ADD37, 32'h124, 0, 0, 0, 0, 0, 0,
                  dec(ADD37, 32'h124, 0, R7_SAME_CYCLE, 0, 32'h1820, 3, 1, 0, 0, 0, 0, 0));
    applyStimulus(1, 1, 0, HALT, 32'h128, 0, 0, 0, 0, 0, 0,
                  dec(ADD37, 32'h124, 0, 32'h1234_5678, 0, 32'h1820, 3, 1, 0, 0, 0, 0, 0));
    // Halt is sticky, ignores flush, and only reset clears it.
    applyStimulus(1, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0,
                  dec(HALT, 32'h128, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    applyStimulus(1, 1, 1, NOP, 0, 0, 0, 0, 0, 0, 0, bub(1, 1));
    applyStimulus(1, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0, bub(1, 1));
    applyStimulus(0, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0, bub(0, 0));
    // Register file was cleared by reset.
    applyStimulus(1, 1, 0, ADD35, 0, 0, 0, 0, 0, 0, 0, bub(0, 0));
    applyStimulus(1, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0,
                  dec(ADD35, 0, 0, 0, 0, 32'h1820, 3, 1, 0, 0, 0, 0, 0));
    // Reset asserted while in BUBBLE.
    applyStimulus(1, 1, 0, SW52, 32'h200, 0, 0, 0, 0, 1, 5, bub(1, 0));
    applyStimulus(0, 1, 0, SW52, 32'h200, 0, 0, 0, 0, 0, 0, bub(0, 0));
    applyStimulus(1, 1, 0, SW52, 32'h200, 0, 0, 0, 0, 0, 0, bub(0, 0));
    applyStimulus(1, 1, 0, NOP, 0, 0, 0, 0, 0, 0, 0,
                  dec(SW52, 32'h200, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0));

    @(negedge CLK);
    #1;
    checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter: HALT_OP, 6'b111111, opcode that halts the pipeline.
REQ-002 SHALL have ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- en  in  1  downstream advance enable
- flush  in  1  squash the held instruction (branch redirect)
- instr_npc  in  32  PC+4 of the incoming instruction
- instruction  in  32  incoming instruction
- branch_taken  in  1  prediction bit of the incoming instruction
- wb_wen  in  1  register write enable
- wb_wsel  in  5  register write index
- wb_wdat  in  32  register write data
- ex_memread  in  1  EX-stage instruction is a load
- ex_wsel  in  5  EX-stage destination register
- stall  out  1  hold the fetch stage (drives fetch en low)
- halt  out  1  pipeline halted
- de_instr, de_npc  out  32 each  registered instruction and npc
- de_branch_taken  out  1  registered prediction
- de_rdat1, de_rdat2  out  32 each  rs and rt register values
- de_imm  out  32  extended immediate
- de_wsel  out  5  destination register
- de_regwen, de_memread, de_memwrite, de_halt  out  1 each  controls

Function
REQ-003 SHALL hold a 32x32 register file; register 0 SHALL read 0 and ignore writes.
REQ-004 SHALL apply register writes on the rising edge when wb_wen=1 and wb_wsel!=0.
REQ-005 SHALL decode fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
REQ-006 SHALL zero-extend imm for opcodes 0x0C/0x0D/0x0E, produce {imm,16'h0} for LUI 0x0F, and sign-extend otherwise.
REQ-007 SHALL set wsel to rd for opcode 0, to 31 for JAL 0x03, and to rt otherwise.
REQ-008 SHALL set regwen=0 for SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JR (op 0, funct 0x08), HALT_OP and all-zero instruction, and regwen=1 otherwise.
REQ-009 SHALL set memread=1 only for LW 0x23 and memwrite=1 only for SW 0x2B.
REQ-010 SHALL register all de_* outputs with one-cycle latency on the edge where the outputs advance.
REQ-011 SHALL use an FSM with states RUN, BUBBLE and HALTED.
REQ-012 SHALL detect a load-use hazard when ex_memread=1, ex_wsel!=0, and either ex_wsel equals rs or ex_wsel equals rt for opcode 0, BEQ, BNE or SW.
REQ-013 In RUN with a hazard, SHALL assert stall combinationally, load a bubble (all de_* = 0) and go to BUBBLE.
REQ-014 In BUBBLE, SHALL re-decode the held instruction, reading the register file again, and return to RUN.
REQ-015 In RUN without a hazard and with en=1, SHALL register the decoded instruction.
REQ-016 When a decoded instruction has opcode HALT_OP and advances, SHALL register de_halt=1 and go to HALTED.
REQ-017 In HALTED, SHALL assert halt=1 and stall=1, emit bubbles, and leave only on reset.
REQ-018 When en=0, SHALL hold all de_* outputs and FSM state and SHALL assert stall=1.
REQ-019 When flush=1 and en=1, SHALL register a bubble and enter RUN from RUN or BUBBLE; flush SHALL take priority over a hazard.
REQ-020 SHALL treat a flush arriving in HALTED as no effect.

Reset
REQ-021 On nRST=0, SHALL immediately clear all de_* outputs, stall, halt and every register-file entry to 0, and enter RUN, including in the middle of a BUBBLE.

Configuration
REQ-022 With WB_BYPASS_EN defined, a read of a register being written in the same cycle (wb_wen=1, wb_wsel equal to the index, index!=0) SHALL return wb_wdat.
REQ-023 Without WB_BYPASS_EN, the same read SHALL return the pre-write value, and the write SHALL be visible on the next cycle.

Verification
REQ-024 SHALL check: write r5=0xDEADBEEF, then decode ADD r3,r5,r0 -> next cycle de_rdat1=0xDEADBEEF, de_wsel=3, de_regwen=1.
REQ-025 SHALL check: ex_memread=1 and ex_wsel=5 while decoding SW r5,0(r2) -> stall=1 for one cycle, one bubble, then SW registered with de_memwrite=1.
REQ-026 SHALL check: ORI with imm 0x8000 -> de_imm=0x00008000; ADDI with imm 0x8000 -> de_imm=0xFFFF8000.
REQ-027 SHALL check: flush=1 coincident with a hazard -> bubble registered, stall=0 the next cycle, and the held instruction discarded.
REQ-028 SHALL check: HALT_OP instruction -> de_halt=1 next cycle, halt=1 and stall=1 persistent, cleared only by nRST=0.
REQ-029 SHALL check: same-cycle write and read of r7=0x12345678 -> de_rdat1=0x12345678 with WB_BYPASS_EN, and the old value without it.
